robot_controller: RTL

- Wall-following control FSM for the pipe-cleaning robot.
- Sits directly downstream of the per-sensor debouncers and consumes their clean sensor levels: head, left, under and barrier.
- Issues one-cycle motion/clean command pulses using a left-hand rule.
- After each command it waits a fixed settle time before sampling the sensors again.

---
 rtl/robot_pkg.sv | 25 ++
 rtl/robot_step_timer.sv | 29 ++
 rtl/robot_controller.sv | 135 +++++++++++++
 3 files changed

// File: rtl/robot_pkg.sv
// Shared encodings for the pipe-cleaning robot wall-follower.
package robot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECIDE = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HALT   = 3'd3
    } state_t;

    typedef enum logic {
        MODE_SEARCH = 1'b0,
        MODE_FOLLOW = 1'b1
    } mode_t;

    // One-hot motion/clean commands; bit order matches {remove, turn_r, turn_l, fwd}.
    typedef enum logic [3:0] {
        CMD_NONE   = 4'b0000,
        CMD_FWD    = 4'b0001,
        CMD_TURN_L = 4'b0010,
        CMD_TURN_R = 4'b0100,
        CMD_REMOVE = 4'b1000
    } cmd_t;

endpackage

// File: rtl/robot_step_timer.sv
// Loadable down-counter used for the settle time after each command pulse.
module robot_step_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count;

    // Load on request, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/robot_controller.sv
// Left-hand-rule wall-following controller: one command pulse per decision,
// followed by a fixed settle wait; floor loss parks the robot until reset.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | one cycle after reset release
// DECIDE | sample sensors, pick command, load settle timer
// WAIT   | command pulse on first cycle, then settle for STEP_CYCLES
// HALT   | floor lost; only reset leaves this state
import robot_pkg::*;

module robot_controller #(
    parameter int STEP_CYCLES  = 1_000_000,
    parameter int REMOVE_TRIES = 3,
    parameter int CNT_W        = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       head,
    input  logic       left,
    input  logic       under,
    input  logic       barrier,
    output logic       fwd,
    output logic       turn_l,
    output logic       turn_r,
    output logic       remove,
    output logic       halted,
    output logic [2:0] state_o
);

    localparam int               TRY_W     = $clog2(REMOVE_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_MAX   = TRY_W'(REMOVE_TRIES);
    localparam logic [TRY_W-1:0] TRY_ONE   = TRY_W'(1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(STEP_CYCLES - 1);

    state_t           state;
    mode_t            mode;
    logic             pending;
    logic [TRY_W-1:0] tries;

    cmd_t             cmd_next;
    mode_t            mode_next;
    logic             pending_next;
    logic [TRY_W-1:0] tries_next;

    logic             timer_load;
    logic             timer_done;

    // The timer is armed on the decision edge so its first WAIT cycle holds STEP_CYCLES-1.
    assign timer_load = (state == ST_DECIDE);

    robot_step_timer #(
        .CNT_W (CNT_W)
    ) u_step_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (WAIT_LOAD),
        .done     (timer_done)
    );

    // Command decode: left-hand rule with a pending forward step after each left turn.
    always_comb begin
        cmd_next  = CMD_NONE;
        mode_next = mode;
        if (pending && !head) begin
            cmd_next = CMD_FWD;
        end else begin
            if (mode == MODE_SEARCH && left) begin
                mode_next = MODE_FOLLOW;
            end
            if (mode_next == MODE_SEARCH) begin
                cmd_next = head ? CMD_TURN_R : CMD_FWD;
            end else if (!left) begin
                cmd_next = CMD_TURN_L;
            end else if (head && barrier && (tries < TRY_MAX)) begin
                cmd_next = CMD_REMOVE;
            end else if (head) begin
                cmd_next = CMD_TURN_R;
            end else begin
                cmd_next = CMD_FWD;
            end
        end
        pending_next = (cmd_next == CMD_TURN_L);
        tries_next   = (cmd_next == CMD_REMOVE) ? (tries + TRY_ONE) : '0;
    end

    // Sequencer with registered command pulses; floor loss beats any decision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            mode    <= MODE_SEARCH;
            pending <= 1'b0;
            tries   <= '0;
            fwd     <= 1'b0;
            turn_l  <= 1'b0;
            turn_r  <= 1'b0;
            remove  <= 1'b0;
            halted  <= 1'b0;
        end else begin
            {remove, turn_r, turn_l, fwd} <= CMD_NONE;
            if (state != ST_HALT && !under) begin
                state  <= ST_HALT;
                halted <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_DECIDE;
                    end
                    ST_DECIDE: begin
                        state                         <= ST_WAIT;
                        {remove, turn_r, turn_l, fwd} <= cmd_next;
                        mode                          <= mode_next;
                        pending                       <= pending_next;
                        tries                         <= tries_next;
                    end
                    ST_WAIT: begin
                        if (timer_done) begin
                            state <= ST_DECIDE;
                        end
                    end
                    ST_HALT: begin
                        state <= ST_HALT;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign state_o = state;

endmodule
